// File: rtl/sim_io_pkg.sv
// sim_io_pkg: shared types, constants and colour helper
// for the sim I/O conditioner.
package sim_io_pkg;

  typedef enum logic [2:0] {
    AC_IDLE,
    AC_WAIT,
    AC_COIN,
    AC_GAP,
    AC_START,
    AC_DONE
  } autocoin_state_t;

  localparam int AUTOCOIN_WAIT_FRAMES = 60;
  localparam int AUTOCOIN_GAP_FRAMES  = 30;
  localparam int START_BTN_IDX        = 6;

  // Repeat the low `bits` of value MSB-first across 8 bits.
  function automatic logic [7:0] expand8(
    input logic [7:0] value,
    input int         bits
  );
    logic [7:0] r;
    logic [2:0] idx;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(bits - 1 - (i % bits));
      r[3'(7 - i)] = value[idx];
    end
    return r;
  endfunction

endpackage

// File: rtl/sim_io_conditioner_coin.sv
// sim_coin_stretch: holds one coin output asserted
// for COIN_FRAMES vblank rises after a press.
module sim_coin_stretch #(
  parameter int COIN_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_i,
  input  logic vb_rise_i,
  input  logic force_i,
  output logic btn_n_o
);

  localparam int CW = $clog2(COIN_FRAMES + 1);

  logic          s_prev_q, s_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_n_q, btn_n_d;

  always_comb begin
    s_prev_d = s_i;
    cnt_d    = cnt_q;
    // a fresh press beats a same-cycle vblank decrement
    if (s_i && !s_prev_q) begin
      cnt_d = CW'(COIN_FRAMES);
    end else if (vb_rise_i && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    btn_n_d = ~((cnt_q != '0) | s_i | force_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev_q <= 1'b0;
      cnt_q    <= '0;
      btn_n_q  <= 1'b1;
    end else begin
      s_prev_q <= s_prev_d;
      cnt_q    <= cnt_d;
      btn_n_q  <= btn_n_d;
    end
  end

  assign btn_n_o = btn_n_q;

endmodule

// File: rtl/sim_io_conditioner.sv
// sim_io_conditioner: sim buttons to core, ce_pix, colour.
// Optional auto-coin sequencer: SIM_AUTOCOIN_EN.
module sim_io_conditioner
  import sim_io_pkg::*;
#(
  parameter int NUM_BTN     = 12,
  parameter int COIN_LSB    = 8,
  parameter int NUM_COIN    = 3,
  parameter int COIN_FRAMES = 3,
  parameter int CE_DIV      = 4,
  parameter int CBITS       = 3
) (
  input  logic               clk_48,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] inputs,
  input  logic               vblank,
  input  logic [3*CBITS-1:0] rgb_i,
  output logic [NUM_BTN-2:0] btn_n_o,
  output logic               pause_o,
  output logic               ce_pix,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b
);

  localparam int DW = $clog2(CE_DIV);
  localparam int PK = NUM_BTN - 1;

  logic [NUM_BTN-1:0] meta_q, meta_d;
  logic [NUM_BTN-1:0] s_q, s_d;
  logic               vb_q, vb_d;
  logic               pk_q, pk_d;
  logic               pause_q, pause_d;
  logic               ce_q, ce_d;
  logic [DW-1:0]      div_q, div_d;
  logic [7:0]         r_q, r_d, g_q, g_d, b_q, b_d;
  logic [7:0]         raw_r, raw_g, raw_b;
  logic               vb_rise;
  logic               ac_coin, ac_start;

  assign vb_rise = vblank & ~vb_q;

  always_comb begin
    meta_d  = inputs;
    s_d     = meta_q;
    vb_d    = vblank;
    pk_d    = s_q[PK];
    pause_d = pause_q ^ (s_q[PK] & ~pk_q);
    ce_d    = (div_q == DW'(CE_DIV - 1));
    div_d   = ce_d ? '0 : div_q + DW'(1);
    raw_r   = '0;
    raw_g   = '0;
    raw_b   = '0;
    raw_r[CBITS-1:0] = rgb_i[CBITS-1:0];
    raw_g[CBITS-1:0] = rgb_i[2*CBITS-1:CBITS];
    raw_b[CBITS-1:0] = rgb_i[3*CBITS-1:2*CBITS];
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (ce_q) begin
      r_d = expand8(raw_r, CBITS);
      g_d = expand8(raw_g, CBITS);
      b_d = expand8(raw_b, CBITS);
    end
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= '0;
      s_q     <= '0;
      vb_q    <= 1'b0;
      pk_q    <= 1'b0;
      pause_q <= 1'b0;
      ce_q    <= 1'b0;
      div_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      meta_q  <= meta_d;
      s_q     <= s_d;
      vb_q    <= vb_d;
      pk_q    <= pk_d;
      pause_q <= pause_d;
      ce_q    <= ce_d;
      div_q   <= div_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

`ifdef SIM_AUTOCOIN_EN
  autocoin_state_t ac_q, ac_d;
  logic [6:0]      fc_q, fc_d;
  logic            fc_last;
  logic            ac_tick;

  always_comb begin
    ac_d     = ac_q;
    fc_d     = fc_q;
    ac_coin  = 1'b0;
    ac_start = 1'b0;
    fc_last  = 1'b0;
    ac_tick  = vb_rise & ~pause_q;
    unique case (ac_q)
      AC_IDLE:  ac_d = AC_WAIT;
      AC_WAIT:  fc_last = fc_q == 7'(AUTOCOIN_WAIT_FRAMES - 1);
      AC_COIN: begin
        ac_coin = 1'b1;
        fc_last = fc_q == 7'(COIN_FRAMES - 1);
      end
      AC_GAP:   fc_last = fc_q == 7'(AUTOCOIN_GAP_FRAMES - 1);
      AC_START: begin
        ac_start = 1'b1;
        fc_last  = fc_q == 7'd1;
      end
      default:  ac_d = AC_DONE;
    endcase
    if (ac_tick && ac_q != AC_IDLE && ac_q != AC_DONE) begin
      fc_d = fc_last ? '0 : fc_q + 7'd1;
      if (fc_last) ac_d = autocoin_state_t'(ac_q + 3'd1);
    end
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      ac_q <= AC_IDLE;
      fc_q <= '0;
    end else begin
      ac_q <= ac_d;
      fc_q <= fc_d;
    end
  end
`else
  assign ac_coin  = 1'b0;
  assign ac_start = 1'b0;
`endif

  for (genvar i = 0; i < NUM_BTN - 1; i++) begin : g_btn
    if (i >= COIN_LSB && i < COIN_LSB + NUM_COIN) begin : g_coin
      sim_coin_stretch #(
        .COIN_FRAMES(COIN_FRAMES)
      ) u_coin (
        .clk       (clk_48),
        .rst_n     (reset_n),
        .s_i       (s_q[i]),
        .vb_rise_i (vb_rise),
        .force_i   ((i == COIN_LSB) ? ac_coin : 1'b0),
        .btn_n_o   (btn_n_o[i])
      );
    end else if (i == START_BTN_IDX) begin : g_start
      assign btn_n_o[i] = ~(s_q[i] | ac_start);
    end else begin : g_plain
      assign btn_n_o[i] = ~s_q[i];
    end
  end

  assign pause_o = pause_q;
  assign ce_pix  = ce_q;
  assign vga_r   = r_q;
  assign vga_g   = g_q;
  assign vga_b   = b_q;

endmodule
